// File: rtl/regfile_serial_loader.sv
// Serial front-end for the 4x4-bit register file: collects 6-bit frames (a1,a0,d3..d0)
// and emits a one-cycle write strobe with parallel address/data; sweeps read address in idle.
module regfile_serial_loader (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    COMMIT   = 2'd2,
    WAIT_LOW = 2'd3
  } state_t;

  logic       clk_s;
  logic       rst_s;
  logic       sdi_s;
  logic       sen_s;
  logic       scan_en_s;
  logic       unused_s;

  state_t     state_r;
  state_t     state_s;
  logic [2:0] count_r;
  logic [2:0] count_s;
  logic [4:0] shift_r;
  logic [4:0] shift_s;
  logic       we_r;
  logic       we_s;
  logic [1:0] addr_r;
  logic [1:0] addr_s;
  logic [3:0] data_r;
  logic [3:0] data_s;
  logic       err_r;
  logic       err_s;

  assign clk_s     = io_in[0];
  assign rst_s     = io_in[1];
  assign sdi_s     = io_in[2];
  assign sen_s     = io_in[3];
  assign scan_en_s = io_in[4];
  assign unused_s  = ^io_in[7:5];

  // Next-state and next-output logic for the frame FSM and address sweep
  always_comb begin
    state_s = state_r;
    count_s = count_r;
    shift_s = shift_r;
    we_s    = 1'b0;
    addr_s  = addr_r;
    data_s  = data_r;
    err_s   = err_r;
    case (state_r)
      IDLE: begin
        if (sen_s) begin
          shift_s = {4'b0000, sdi_s};
          count_s = 3'd1;
          state_s = SHIFT;
        end else if (scan_en_s) begin
          addr_s = addr_r + 2'd1;
        end else begin
          addr_s = addr_r;
        end
      end
      SHIFT: begin
        if (sen_s) begin
          // count==5 means this edge samples the sixth and last frame bit
          if (count_r == 3'd5) begin
            addr_s  = shift_r[4:3];
            data_s  = {shift_r[2:0], sdi_s};
            we_s    = 1'b1;
            err_s   = 1'b0;
            count_s = 3'd0;
            state_s = COMMIT;
          end else begin
            shift_s = {shift_r[3:0], sdi_s};
            count_s = count_r + 3'd1;
          end
        end else begin
          err_s   = 1'b1;
          count_s = 3'd0;
          shift_s = 5'd0;
          state_s = IDLE;
        end
      end
      COMMIT: begin
        if (sen_s) begin
          state_s = WAIT_LOW;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT_LOW: begin
        if (sen_s) begin
          state_s = WAIT_LOW;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
        count_s = 3'd0;
        shift_s = 5'd0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_s) begin
    if (rst_s) begin
      state_r <= IDLE;
      count_r <= 3'd0;
      shift_r <= 5'd0;
      we_r    <= 1'b0;
      addr_r  <= 2'd0;
      data_r  <= 4'd0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      count_r <= count_s;
      shift_r <= shift_s;
      we_r    <= we_s;
      addr_r  <= addr_s;
      data_r  <= data_s;
      err_r   <= err_s;
    end
  end

  assign io_out = {err_r, data_r, addr_r, we_r};

endmodule

// File: tb/tb_regfile_serial_loader.sv
// Directed bench for regfile_serial_loader; io_out = {err, data[3:0], addr[1:0], we}.
module tb_regfile_serial_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sdi = 1'b0;
  logic       sen = 1'b0;
  logic       scan_en = 1'b0;
  logic [2:0] junk = 3'd0;
  logic [7:0] io_in;
  logic [7:0] io_out;
  int         tests = 0;
  int         fails = 0;

  assign io_in = {junk, scan_en, sen, sdi, rst, clk};

  regfile_serial_loader dut (
    .io_in  (io_in),
    .io_out (io_out)
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic e, input logic d, input logic s,
                      input logic [7:0] exp, input string tag);
    @(negedge clk);
    rst     = r;
    sen     = e;
    sdi     = d;
    scan_en = s;
    junk    = 3'($urandom_range(0, 7));
    @(posedge clk);
    #1;
    tests++;
    assert (io_out === exp) else begin
      fails++;
      $error("FAIL %s: io_out=%h expected %h", tag, io_out, exp);
    end
  endtask

  initial begin
    // Reset for two cycles, then idle
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "rst0");
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "rst1");
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, "idle");

    // Frame addr=2 data=B: bits 1,0,1,0,1,1
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, "f1_b1");
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, "f1_b2");
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, "f1_b3");
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, "f1_b4");
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, "f1_b5");
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h5D, "f1_commit");
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h5C, "f1_hold");
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h5C, "f1_hold2");

    // Scan from addr=2: 3,0,1,2,3,0
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h5E, "scan3");
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h58, "scan0");
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, "scan1");
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h5C, "scan2");
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h5E, "scan3b");
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h58, "scan0b");

    // sen beats scan_en: addr frozen at 0, frame starts; abort after 3 bits
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'h58, "scan_freeze");
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h58, "ab_b2");
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'h58, "ab_b3");
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'hD8, "abort_err");
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'hD8, "abort_hold");

    // Frame addr=1 data=5: bits 0,1,0,1,0,1 clears err
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'hD8, "f2_b1");
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'hD8, "f2_b2");
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'hD8, "f2_b3");
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'hD8, "f2_b4");
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'hD8, "f2_b5");
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h2B, "f2_commit");
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h2A, "f2_hold");

    // Long sen: addr=3 data=F, then four extra bits ignored
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 8'h2A, "f3_bits");
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h7F, "f3_commit");
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h7E, "f3_x7");
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'h7E, "f3_x8");
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h7E, "f3_x9");
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h7E, "f3_x10");
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h7E, "f3_low");
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h78, "f3_idle_scan");

    // Reset after 4 frame bits, then frame addr=0 data=9: bits 0,0,1,0,0,1
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h78, "rf_b1");
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h78, "rf_b2");
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h78, "rf_b3");
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h78, "rf_b4");
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, "rf_rst");
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, "rf_after");
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, "f4_b1");
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, "f4_b2");
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, "f4_b3");
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, "f4_b4");
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, "f4_b5");
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h49, "f4_commit");
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h48, "f4_hold");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
